// File: rtl/apb_pkg.sv
// apb_pkg
// Shared types and constants for the APB master/arbiter slice: the bus-phase
// state encoding, the slave index map and default bus widths.
// No ports (package).

package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    // Slave index = top two address bits.
    localparam int WDT   = 0;
    localparam int TMR   = 1;
    localparam int GPIO  = 2;
    localparam int SPARE = 3;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 21;
    localparam int DEF_NUM_SLV = 4;
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-input round-robin arbiter. When both eligible requesters are active the
// one not granted last wins; a lone eligible requester always wins. The
// last-grant record only moves when the owner accepts a grant via advance.
//
// Ports:
//   pclk     in   clock, rising edge
//   presetn  in   synchronous active-low reset
//   req      in   [1:0] raw requests
//   mask     in   [1:0] requests to ignore this cycle
//   advance  in   grant accepted this cycle; record the winner
//   gnt      out  [1:0] one-hot grant (zero when nothing eligible)

module rr_arbiter2
    import apb_pkg::*;
(
    input  logic       pclk,
    input  logic       presetn,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic       last_gnt;
    logic [1:0] eligible;

    assign eligible = req & ~mask;

    // Tie goes to whoever did not win last time.
    always_comb begin
        gnt = eligible;
        if (eligible == 2'b11) begin
            gnt = last_gnt ? 2'b01 : 2'b10;
        end
    end

    // Reset to "requester 1 won last" so requester 0 takes the first tie.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            last_gnt <= 1'b1;
        end else if (advance && (gnt != 2'b00)) begin
            last_gnt <= gnt[1];
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
// APB master shared by two requesters. Arbitrates round-robin, drives the
// SETUP/ACCESS sequence to one of NUM_SLV slaves selected by the top two
// address bits, waits on the selected slave's pready and aborts with err
// after TIMEOUT ACCESS cycles. All outputs are registered.
//
// Ports:
//   pclk, presetn              clock / synchronous active-low reset
//   req[1:0]                   per-requester request, held until done
//   req_addr0/1, req_write0/1, req_wdata0/1   request payloads
//   done[1:0]                  one-cycle completion pulse per requester
//   err                        with done: 1 = timeout abort
//   rdata                      read data, held until next completion
//   psel, penable, pwrite, paddr, pwdata      APB master outputs
//   prdata                     packed per-slave read data, slave 0 in LSBs
//   pready                     per-slave ready

module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_SLV = DEF_NUM_SLV,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic [1:0]                req,
    input  logic [ADDR_W-1:0]         req_addr0,
    input  logic [ADDR_W-1:0]         req_addr1,
    input  logic                      req_write0,
    input  logic                      req_write1,
    input  logic [DATA_W-1:0]         req_wdata0,
    input  logic [DATA_W-1:0]         req_wdata1,
    output logic [1:0]                done,
    output logic                      err,
    output logic [DATA_W-1:0]         rdata,
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready
);

    localparam int WAIT_W = $clog2(TIMEOUT);

    apb_state_e          state, state_nxt;
    logic                gnt_idx, gnt_idx_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic [NUM_SLV-1:0]  psel_nxt;
    logic                penable_nxt;
    logic                pwrite_nxt;
    logic [ADDR_W-1:0]   paddr_nxt;
    logic [DATA_W-1:0]   pwdata_nxt;
    logic [1:0]          done_nxt;
    logic                err_nxt;
    logic [DATA_W-1:0]   rdata_nxt;

    logic [1:0]          arb_gnt;
    logic [1:0]          arb_mask;
    logic                start;

    logic [1:0]          sel_idx;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;
    logic                timed_out;
    logic                finishing;

    logic                win;
    logic [ADDR_W-1:0]   win_addr;
    logic                win_write;
    logic [DATA_W-1:0]   win_wdata;
    logic [NUM_SLV-1:0]  win_psel;

    // Only the slave addressed by the latched paddr is observed.
    assign sel_idx   = paddr[ADDR_W-1 -: 2];
    assign sel_ready = pready[sel_idx];
    assign sel_rdata = prdata[int'(sel_idx)*DATA_W +: DATA_W];

    assign timed_out = (wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign finishing = (state == ACCESS) && (sel_ready || timed_out);

    // A requester is not eligible while its done pulse is out, nor on the
    // edge that completes its own transfer, so a held req is not re-granted.
    assign arb_mask = done | (finishing ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00);

    assign win       = arb_gnt[1];
    assign win_addr  = win ? req_addr1  : req_addr0;
    assign win_write = win ? req_write1 : req_write0;
    assign win_wdata = win ? req_wdata1 : req_wdata0;
    assign win_psel  = NUM_SLV'(1) << win_addr[ADDR_W-1 -: 2];

    rr_arbiter2 u_arb (
        .pclk    (pclk),
        .presetn (presetn),
        .req     (req),
        .mask    (arb_mask),
        .advance (start),
        .gnt     (arb_gnt)
    );

    // Next-state and next-output logic; everything lands in registers.
    always_comb begin
        state_nxt   = state;
        gnt_idx_nxt = gnt_idx;
        wait_nxt    = wait_cnt;
        psel_nxt    = psel;
        penable_nxt = penable;
        pwrite_nxt  = pwrite;
        paddr_nxt   = paddr;
        pwdata_nxt  = pwdata;
        done_nxt    = 2'b00;
        err_nxt     = 1'b0;
        rdata_nxt   = rdata;
        start       = 1'b0;

        unique case (state)
            IDLE: begin
                start = (arb_gnt != 2'b00);
            end
            SETUP: begin
                penable_nxt = 1'b1;
                wait_nxt    = '0;
                state_nxt   = ACCESS;
            end
            ACCESS: begin
                if (finishing) begin
                    done_nxt[gnt_idx] = 1'b1;
                    // Reaching here without ready means the wait budget ran out.
                    err_nxt = !sel_ready;
                    if (!sel_ready) begin
                        rdata_nxt = '0;
                    end else if (!pwrite) begin
                        rdata_nxt = sel_rdata;
                    end
                    if (arb_gnt != 2'b00) begin
                        start = 1'b1;
                    end else begin
                        psel_nxt    = '0;
                        penable_nxt = 1'b0;
                        state_nxt   = IDLE;
                    end
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                psel_nxt    = '0;
                penable_nxt = 1'b0;
                state_nxt   = IDLE;
            end
        endcase

        // Latching a new winner is shared by IDLE and back-to-back ACCESS exit.
        if (start) begin
            state_nxt   = SETUP;
            gnt_idx_nxt = win;
            psel_nxt    = win_psel;
            penable_nxt = 1'b0;
            pwrite_nxt  = win_write;
            paddr_nxt   = win_addr;
            pwdata_nxt  = win_wdata;
        end
    end

    // State and output registers.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state    <= IDLE;
            gnt_idx  <= 1'b0;
            wait_cnt <= '0;
            psel     <= '0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            paddr    <= '0;
            pwdata   <= '0;
            done     <= 2'b00;
            err      <= 1'b0;
            rdata    <= '0;
        end else begin
            state    <= state_nxt;
            gnt_idx  <= gnt_idx_nxt;
            wait_cnt <= wait_nxt;
            psel     <= psel_nxt;
            penable  <= penable_nxt;
            pwrite   <= pwrite_nxt;
            paddr    <= paddr_nxt;
            pwdata   <= pwdata_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            rdata    <= rdata_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter
// Self-checking bench for apb_master_arbiter. Acts as both requesters and all
// four slaves, and predicts each transfer's outcome (grant, slave select,
// ACCESS length, done/err, rdata) from the transfer rules directly.

module tb_apb_master_arbiter;
    import apb_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 21;
    localparam int NUM_SLV = 4;
    localparam int TIMEOUT = 16;

    logic                      pclk;
    logic                      presetn;
    logic [1:0]                req;
    logic [ADDR_W-1:0]         req_addr0, req_addr1;
    logic                      req_write0, req_write1;
    logic [DATA_W-1:0]         req_wdata0, req_wdata1;
    logic [1:0]                done;
    logic                      err;
    logic [DATA_W-1:0]         rdata;
    logic [NUM_SLV-1:0]        psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_W-1:0]         paddr;
    logic [DATA_W-1:0]         pwdata;
    logic [NUM_SLV*DATA_W-1:0] prdata;
    logic [NUM_SLV-1:0]        pready;

    int              testsRun;
    int              failCount;
    int              modelLast;
    logic [DATA_W-1:0] modelRdata;

    apb_master_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NUM_SLV (NUM_SLV),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .req        (req),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_write0 (req_write0),
        .req_write1 (req_write1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int r, input logic [ADDR_W-1:0] a, input logic w,
                                 input logic [DATA_W-1:0] d);
        if (r == 0) begin
            req_addr0 = a; req_write0 = w; req_wdata0 = d;
        end else begin
            req_addr1 = a; req_write1 = w; req_wdata1 = d;
        end
        req[r] = 1'b1;
    endtask

    task automatic applyReset();
        presetn = 1'b0;
        req     = 2'b00;
        pready  = '0;
        @(negedge pclk);
        @(negedge pclk);
        checkOutput("reset psel",    psel,    0);
        checkOutput("reset penable", penable, 0);
        checkOutput("reset pbus",    {pwrite, paddr, pwdata}, 0);
        checkOutput("reset done",    {done, err}, 0);
        checkOutput("reset rdata",   rdata,   0);
        presetn    = 1'b1;
        modelLast  = 1;
        modelRdata = '0;
    endtask

    // One isolated transfer from requester r; waits >= TIMEOUT means the
    // selected slave never becomes ready.
    task automatic singleTransfer(input string tag, input int r, input logic [ADDR_W-1:0] a,
                                  input logic w, input logic [DATA_W-1:0] d, input int waits,
                                  input logic noiseAll, input logic useFixed,
                                  input logic [DATA_W-1:0] fixedVal);
        int                sel;
        int                k;
        int                expCycles;
        logic              expErr;
        logic [NUM_SLV-1:0] expPsel;
        logic              finished;
        logic              stableOk;
        logic [DATA_W-1:0] slaveVal;
        logic [95:0]       rnd;

        sel       = int'(a[7:6]);
        expPsel   = 4'(1 << sel);
        expErr    = (waits >= TIMEOUT);
        expCycles = expErr ? TIMEOUT : waits + 1;

        @(negedge pclk);
        applyStimulus(r, a, w, d);
        @(negedge pclk);
        checkOutput({tag, " setup psel"},    psel,    expPsel);
        checkOutput({tag, " setup penable"}, penable, 0);
        checkOutput({tag, " setup bus"},     {paddr, pwrite, pwdata}, {a, w, d});
        modelLast = r;

        @(negedge pclk);
        k        = 0;
        finished = 1'b0;
        stableOk = 1'b1;
        slaveVal = '0;
        while (!finished && k < TIMEOUT + 4) begin
            stableOk &= (psel === expPsel) && (penable === 1'b1) && (paddr === a) &&
                        (pwrite === w) && (pwdata === d) && (done === 2'b00);
            rnd    = {$urandom(), $urandom(), $urandom()};
            prdata = rnd[NUM_SLV*DATA_W-1:0];
            if (useFixed) prdata[sel*DATA_W +: DATA_W] = fixedVal;
            slaveVal = prdata[sel*DATA_W +: DATA_W];
            pready   = noiseAll ? 4'hF : 4'($urandom_range(0, 15));
            pready[sel] = (k >= waits);
            @(negedge pclk);
            k++;
            if (done !== 2'b00) finished = 1'b1;
        end
        req    = 2'b00;
        pready = '0;

        if (expErr)  modelRdata = '0;
        else if (!w) modelRdata = slaveVal;

        checkOutput({tag, " completed"},     finished, 1);
        checkOutput({tag, " access stable"}, stableOk, 1);
        checkOutput({tag, " access cycles"}, k, expCycles);
        checkOutput({tag, " done"},          done, 1 << r);
        checkOutput({tag, " err"},           err, expErr);
        checkOutput({tag, " rdata"},         rdata, modelRdata);
        checkOutput({tag, " bus idle"},      {psel, penable}, 0);
    endtask

    initial begin
        int          grants;
        int          cyc;
        int          lastG;
        int          idleSeen;
        int          expG;
        logic [95:0] rnd;

        testsRun   = 0;
        failCount  = 0;
        req        = 2'b00;
        req_addr0  = '0; req_addr1  = '0;
        req_write0 = 1'b0; req_write1 = 1'b0;
        req_wdata0 = '0; req_wdata1 = '0;
        prdata     = '0;
        pready     = '0;

        applyReset();

        // Zero-wait read from slave 0.
        singleTransfer("rd0", 0, 8'h05, 1'b0, 21'($urandom()), 0, 1'b0, 1'b1, 21'h1ABCD);
        checkOutput("rd0 rdata value", rdata, 21'h1ABCD);

        // Write to slave 1 with three wait states; rdata must not move.
        singleTransfer("wr1", 1, 8'h45, 1'b1, 21'h00123, 3, 1'b0, 1'b0, '0);
        checkOutput("wr1 rdata kept", rdata, 21'h1ABCD);

        // Slave 2 hangs while every other slave is ready: timeout abort.
        singleTransfer("to2", 0, 8'h80, 1'b0, 21'($urandom()), TIMEOUT, 1'b1, 1'b0, '0);

        // Randomized isolated transfers.
        for (int n = 0; n < 16; n++) begin
            singleTransfer($sformatf("rnd%0d", n), int'($urandom_range(0, 1)), 8'($urandom()),
                           1'($urandom()), 21'($urandom()),
                           ($urandom_range(0, 7) == 0) ? TIMEOUT : int'($urandom_range(0, 4)),
                           1'b0, 1'b0, '0);
        end

        // Both requesters held high from reset: alternating back-to-back grants.
        applyReset();
        @(negedge pclk);
        req_addr0  = {2'(WDT),   6'($urandom())};
        req_addr1  = {2'(SPARE), 6'($urandom())};
        req_write0 = 1'($urandom());
        req_write1 = 1'($urandom());
        req_wdata0 = 21'($urandom());
        req_wdata1 = 21'($urandom());
        rnd        = {$urandom(), $urandom(), $urandom()};
        prdata     = rnd[NUM_SLV*DATA_W-1:0];
        pready     = 4'hF;
        req        = 2'b11;
        grants     = 0;
        cyc        = 0;
        lastG      = -1;
        idleSeen   = 0;
        while (grants < 6 && cyc < 40) begin
            @(negedge pclk);
            cyc++;
            if (done !== 2'b00 && lastG >= 0) begin
                checkOutput("b2b done owner", done, 1 << lastG);
            end
            if (psel !== '0 && penable === 1'b0) begin
                expG = 1 - modelLast;
                checkOutput($sformatf("b2b grant %0d", grants), psel,
                            (expG == 0) ? 4'b0001 : 4'b1000);
                modelLast = expG;
                lastG     = expG;
                grants++;
            end
            if (grants > 0 && psel === '0) idleSeen++;
        end
        req = 2'b00;
        checkOutput("b2b grant count", grants, 6);
        checkOutput("b2b idle cycles", idleSeen, 0);
        repeat (4) @(negedge pclk);
        checkOutput("b2b drained", {psel, penable}, 0);
        pready = '0;

        // Reset in the middle of an ACCESS phase.
        @(negedge pclk);
        applyStimulus(0, 8'h9A, 1'b0, 21'($urandom()));
        repeat (4) @(negedge pclk);
        checkOutput("rstmid in access", {psel, penable}, {4'b0100, 1'b1});
        presetn = 1'b0;
        @(negedge pclk);
        req = 2'b00;
        checkOutput("rstmid bus released", {psel, penable}, 0);
        checkOutput("rstmid no done", {done, err}, 0);
        presetn    = 1'b1;
        modelLast  = 1;
        modelRdata = '0;
        @(negedge pclk);
        checkOutput("rstmid still quiet", {done, psel, penable}, 0);
        checkOutput("rstmid rdata", rdata, modelRdata);

        // First tie after reset goes to requester 0.
        applyStimulus(0, {2'(TMR),  6'($urandom())}, 1'b1, 21'($urandom()));
        applyStimulus(1, {2'(GPIO), 6'($urandom())}, 1'b1, 21'($urandom()));
        pready = 4'hF;
        @(negedge pclk);
        req  = 2'b00;
        expG = 1 - modelLast;
        checkOutput("tie after reset", psel, (expG == 0) ? 4'b0010 : 4'b0100);
        @(negedge pclk);
        @(negedge pclk);
        checkOutput("tie done owner", done, 1 << expG);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
